xs3_serial_to_bcd: RTL

//  Bit-serial Excess-3 -> BCD decoder: the receive side of the BCD -> Excess-3 converter link.

---
 rtl/xs3_serial_to_bcd.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/xs3_serial_to_bcd.sv
// xs3_serial_to_bcd
// Bit-serial Excess-3 to BCD decoder. XS3 code bits arrive LSB first. The
// decoder subtracts 3 (0011) one bit at a time, using a borrow state machine.
// For every accepted bit it emits the decoded bit. It also emits a parallel
// digit every 4 bits and a packed word every NDIG digits.
//
// Ports
//   clk          clock, all logic on posedge
//   rst          synchronous reset, active-high
//   in_valid     in_bit is accepted this cycle
//   in_bit       XS3 code bit, LSB first
//   in_sof       with in_valid: bit0 of digit0 (resynchronises framing)
//   out_valid    1-cycle pulse per accepted bit, out_bit valid
//   out_bit      decoded BCD bit, LSB first
//   digit_valid  1-cycle pulse, bcd/dig_err valid
//   bcd          decoded digit (held between pulses)
//   dig_err      code was below 0011 or above 1100
//   word_valid   1-cycle pulse, word/word_err valid
//   word         digit k in [4k+3:4k], digit0 in [3:0]
//   word_err     OR of dig_err over the word
//   busy         a partial digit or word is in progress
//
// Handshake: there is no backpressure. A bit is consumed on every posedge
// where in_valid=1. Each output pulse lasts exactly one cycle and appears one
// cycle after the bit that caused it.
module xs3_serial_to_bcd #(
    parameter int NDIG = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              in_sof,
    output logic              out_valid,
    output logic              out_bit,
    output logic              digit_valid,
    output logic [3:0]        bcd,
    output logic              dig_err,
    output logic              word_valid,
    output logic [4*NDIG-1:0] word,
    output logic              word_err,
    output logic              busy
);
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    typedef enum logic {
        BRW_CLEAR = 1'b0,
        BRW_PEND  = 1'b1
    } borrow_e;

    // State registers
    logic [1:0]        bit_idx_q, bit_idx_d;
    borrow_e           borrow_q, borrow_d;
    logic [CW-1:0]     dig_cnt_q, dig_cnt_d;
    logic [3:0]        dbits_q, dbits_d;
    logic [4*NDIG-1:0] wacc_q, wacc_d;
    logic              err_acc_q, err_acc_d;

    // Registered outputs
    logic              out_valid_q, out_bit_q, digit_valid_q, dig_err_q;
    logic              word_valid_q, word_err_q, busy_q;
    logic [3:0]        bcd_q;
    logic [4*NDIG-1:0] word_q;

    // Combinational helpers
    logic [1:0]    idx_eff;
    logic [CW-1:0] cnt_eff;
    logic          err_eff, s_bit, b_eff, ob, nb, derr, last_bit, last_dig;
    logic [3:0]    digit;

    always_comb begin
        // in_sof restarts the framing, so the bit is decoded as bit0 of digit0.
        idx_eff  = in_sof ? 2'd0 : bit_idx_q;
        cnt_eff  = in_sof ? '0 : dig_cnt_q;
        err_eff  = in_sof ? 1'b0 : err_acc_q;
        // The subtrahend 0011 is 1 for bit positions 0 and 1.
        s_bit    = ~idx_eff[1];
        // Each digit starts with no borrow, so no borrow crosses a digit boundary.
        b_eff    = (idx_eff == 2'd0) ? 1'b0 : (borrow_q == BRW_PEND);
        ob       = in_bit ^ s_bit ^ b_eff;
        nb       = (~in_bit & (s_bit | b_eff)) | (s_bit & b_eff);
        dbits_d  = dbits_q;
        dbits_d[idx_eff] = ob;
        digit    = dbits_d;
        // A final borrow means the code was below 0011.
        derr     = nb | (digit > 4'd9);
        last_bit = (idx_eff == 2'd3);
        last_dig = (cnt_eff == LAST_DIG);
        wacc_d   = wacc_q;
        if (last_bit) begin
            for (int k = 0; k < NDIG; k++) begin
                if (cnt_eff == CW'(k)) wacc_d[4*k +: 4] = digit;
            end
        end
        bit_idx_d = idx_eff + 2'd1;
        borrow_d  = nb ? BRW_PEND : BRW_CLEAR;
        dig_cnt_d = cnt_eff;
        err_acc_d = err_eff;
        if (last_bit) begin
            if (last_dig) begin
                dig_cnt_d = '0;
                err_acc_d = 1'b0;
            end else begin
                dig_cnt_d = cnt_eff + CW'(1);
                err_acc_d = err_eff | derr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx_q     <= 2'd0;
            borrow_q      <= BRW_CLEAR;
            dig_cnt_q     <= '0;
            dbits_q       <= 4'd0;
            wacc_q        <= '0;
            err_acc_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_bit_q     <= 1'b0;
            digit_valid_q <= 1'b0;
            bcd_q         <= 4'd0;
            dig_err_q     <= 1'b0;
            word_valid_q  <= 1'b0;
            word_q        <= '0;
            word_err_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            out_valid_q   <= in_valid;
            digit_valid_q <= 1'b0;
            word_valid_q  <= 1'b0;
            if (in_valid) begin
                out_bit_q <= ob;
                bit_idx_q <= bit_idx_d;
                borrow_q  <= borrow_d;
                dbits_q   <= dbits_d;
                wacc_q    <= wacc_d;
                dig_cnt_q <= dig_cnt_d;
                err_acc_q <= err_acc_d;
                busy_q    <= (bit_idx_d != 2'd0) | (dig_cnt_d != '0);
                if (last_bit) begin
                    digit_valid_q <= 1'b1;
                    bcd_q         <= digit;
                    dig_err_q     <= derr;
                    if (last_dig) begin
                        word_valid_q <= 1'b1;
                        word_q       <= wacc_d;
                        word_err_q   <= err_eff | derr;
                    end
                end
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_bit     = out_bit_q;
    assign digit_valid = digit_valid_q;
    assign bcd         = bcd_q;
    assign dig_err     = dig_err_q;
    assign word_valid  = word_valid_q;
    assign word        = word_q;
    assign word_err    = word_err_q;
    assign busy        = busy_q;

endmodule
